// File: rtl/lfsr_step_ctrl.sv
// Shift-enable generator for a 16-bit LFSR: debounced single-step or divided free-run
// pulses, optional auto-halt on sequence wrap, plus a shift counter and sticky wrap flag.

module lfsr_step_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;

  // 2-flop synchroniser followed by a consecutive-disagreement counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r  <= 2'b00;
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], din};
      if (sync_r[1] != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync_r[1];
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign level = level_r;

endmodule

module lfsr_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RATE_DIV        = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_step,
  input  logic        sw_run,
  input  logic        sw_stop_wrap,
  input  logic        max_tick,
  output logic        sh_en,
  output logic        running,
  output logic [15:0] step_count,
  output logic        wrapped
);

  localparam int DW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RATE_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  logic btn_db_s;
  logic run_db_s;
  logic stop_db_s;

  lfsr_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
    .clk   (clk),
    .reset (reset),
    .din   (btn_step),
    .level (btn_db_s)
  );

  lfsr_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk   (clk),
    .reset (reset),
    .din   (sw_run),
    .level (run_db_s)
  );

  lfsr_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
    .clk   (clk),
    .reset (reset),
    .din   (sw_stop_wrap),
    .level (stop_db_s)
  );

  state_t          state_r;
  state_t          state_next_s;
  logic [DW-1:0]   div_r;
  logic [DW-1:0]   div_next_s;
  logic            btn_db_d_r;
  logic            step_req_s;
  logic            sh_en_r;
  logic            sh_en_next_s;
  logic            running_r;
  logic [15:0]     step_count_r;
  logic            wrapped_r;

  assign step_req_s = btn_db_s & ~btn_db_d_r;

  // Next-state, divider and pulse decision; a low run switch overrides everything
  always_comb begin
    state_next_s = state_r;
    div_next_s   = div_r;
    sh_en_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sh_en_next_s = step_req_s;
        if (run_db_s) begin
          state_next_s = ST_RUN;
          div_next_s   = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!run_db_s) begin
          state_next_s = ST_IDLE;
        end else if (max_tick && stop_db_s) begin
          state_next_s = ST_HALT;
        end else begin
          sh_en_next_s = (div_r == DIV_LAST);
          if (div_r == DIV_LAST) begin
            div_next_s = '0;
          end else begin
            div_next_s = div_r + DIV_ONE;
          end
        end
      end
      ST_HALT: begin
        if (!run_db_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        div_next_s   = '0;
        sh_en_next_s = 1'b0;
      end
    endcase
  end

  // State, divider and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      div_r        <= '0;
      btn_db_d_r   <= 1'b0;
      sh_en_r      <= 1'b0;
      running_r    <= 1'b0;
      step_count_r <= 16'd0;
      wrapped_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      div_r        <= div_next_s;
      btn_db_d_r   <= btn_db_s;
      sh_en_r      <= sh_en_next_s;
      running_r    <= (state_next_s == ST_RUN);
      step_count_r <= step_count_r + {15'd0, sh_en_r};
      wrapped_r    <= wrapped_r | max_tick;
    end
  end

  assign sh_en      = sh_en_r;
  assign running    = running_r;
  assign step_count = step_count_r;
  assign wrapped    = wrapped_r;

endmodule
